// File: rtl/bsg_link_credit_sender_if.sv
// Handshake and link-side signal bundle for the comm-link credit sender.
// The slave modport is the sender itself; the master modport is whatever
// environment feeds it words and returns tokens (upstream logic plus the
// receiver side of the link).
interface bsg_link_credit_sender_if #(
  parameter int width_p      = 9,
  parameter int credit_max_p = 16
);

  localparam int credit_width_lp = $clog2(credit_max_p + 1);

  // Upstream ready/valid word stream
  logic                       v_i;
  logic [width_p-1:0]         data_i;
  logic                       ready_o;

  // Registered stream toward the swizzle adapter (co_v / co_data)
  logic                       link_v_o;
  logic [width_p-1:0]         link_data_o;

  // Token toggle returned by the receiver, already in this clock domain
  logic                       link_tkn_i;

  // Status views
  logic [credit_width_lp-1:0] credits_o;
  logic                       active_o;
  logic                       error_o;

  modport master (
    output v_i,
    output data_i,
    output link_tkn_i,
    input  ready_o,
    input  link_v_o,
    input  link_data_o,
    input  credits_o,
    input  active_o,
    input  error_o
  );

  modport slave (
    input  v_i,
    input  data_i,
    input  link_tkn_i,
    output ready_o,
    output link_v_o,
    output link_data_o,
    output credits_o,
    output active_o,
    output error_o
  );

endinterface

// File: rtl/bsg_link_credit_sender.sv
// Transmit stage of one comm-link channel. Words accepted on the ready/valid
// side are registered onto the link one cycle later. Each word spends one
// credit; every edge of the receiver's token toggle returns a batch of
// credit_decimation_p credits. After reset the link stays idle for
// startup_cycles_p cycles so the far side can come out of reset first.
// credit_max_p is expected to be a multiple of credit_decimation_p, and
// startup_cycles_p must be at least 1.
module bsg_link_credit_sender #(
  parameter int width_p             = 9,
  parameter int credit_max_p        = 16,
  parameter int credit_decimation_p = 4,
  parameter int startup_cycles_p    = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bsg_link_credit_sender_if.slave link
);

  localparam int credit_width_lp = $clog2(credit_max_p + 1);
  // One extra bit so a full counter plus a token batch cannot wrap before
  // the overflow comparison sees it.
  localparam int sum_width_lp    = credit_width_lp + 1;
  localparam int wait_width_lp   = (startup_cycles_p > 1) ? $clog2(startup_cycles_p) : 1;

  typedef enum logic {
    S_WAIT   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e                     state_r;
  state_e                     state_n;
  logic [wait_width_lp-1:0]   wait_cnt_r;
  logic                       wait_done;

  logic                       tkn_r;
  logic                       tkn_edge;

  logic [credit_width_lp-1:0] credits_r;
  logic [credit_width_lp-1:0] credits_n;
  logic [sum_width_lp-1:0]    credit_sum;
  logic                       credit_overflow;
  logic                       error_r;

  logic                       ready;
  logic                       active;
  logic                       xfer;

  logic                       link_v_r;
  logic [width_p-1:0]         link_data_r;

  assign wait_done = (wait_cnt_r == wait_width_lp'(startup_cycles_p - 1));
  assign xfer      = link.v_i & ready;
  assign tkn_edge  = link.link_tkn_i ^ tkn_r;

  // State register: back to the startup wait on every reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= S_WAIT;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state: leave the wait once the startup count is used up; active is terminal
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      S_WAIT:   if (wait_done) state_n = S_ACTIVE;
      S_ACTIVE: state_n = S_ACTIVE;
      default:  state_n = S_WAIT;
    endcase
  end

  // FSM outputs: offer ready only when active and at least one credit is held
  always_comb begin
    active = 1'b0;
    ready  = 1'b0;
    unique case (state_r)
      S_WAIT: begin
        active = 1'b0;
        ready  = 1'b0;
      end
      S_ACTIVE: begin
        active = 1'b1;
        ready  = (credits_r != '0);
      end
      default: begin
        active = 1'b0;
        ready  = 1'b0;
      end
    endcase
  end

  // Startup counter: counts idle cycles while waiting, frozen once active
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_cnt_r <= '0;
    end else if (state_r == S_WAIT && !wait_done) begin
      wait_cnt_r <= wait_cnt_r + 1'b1;
    end
  end

  // Token history: captured even in reset so no spurious edge appears afterwards
  always_ff @(posedge clk_i) begin
    tkn_r <= link.link_tkn_i;
  end

  // Credit update: spend on transfer, refill on token edge, clamp on overflow
  always_comb begin
    credit_sum = sum_width_lp'(credits_r) - sum_width_lp'(xfer);
    if (tkn_edge) begin
      credit_sum = credit_sum + sum_width_lp'(credit_decimation_p);
    end
    credit_overflow = (credit_sum > sum_width_lp'(credit_max_p));
    if (credit_overflow) begin
      credits_n = credit_width_lp'(credit_max_p);
    end else begin
      credits_n = credit_sum[credit_width_lp-1:0];
    end
  end

  // Credit register and sticky overflow flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits_r <= credit_width_lp'(credit_max_p);
      error_r   <= 1'b0;
    end else begin
      credits_r <= credits_n;
      error_r   <= error_r | credit_overflow;
    end
  end

  // Link output register: valid pulses per accepted word, data holds otherwise
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      link_v_r    <= 1'b0;
      link_data_r <= '0;
    end else begin
      link_v_r <= xfer;
      if (xfer) begin
        link_data_r <= link.data_i;
      end
    end
  end

  assign link.ready_o     = ready;
  assign link.link_v_o    = link_v_r;
  assign link.link_data_o = link_data_r;
  assign link.credits_o   = credits_r;
  assign link.active_o    = active;
  assign link.error_o     = error_r;

endmodule

// File: tb/tb_bsg_link_credit_sender.sv
// Self-checking bench for bsg_link_credit_sender with a cycle-level
// behavioural model of credits, startup delay and the link register.
module tb_bsg_link_credit_sender;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int errors = 0;
  int checks = 0;

  // Behavioural model: cycles since reset, credit count, sticky error, link register
  int         m_cyc = 0;
  int         m_cred = 16;
  bit         m_err = 1'b0;
  bit         m_tkn_prev = 1'b0;
  bit         exp_link_v = 1'b0;
  logic [8:0] exp_data = '0;
  bit         exp_ready = 1'b0;
  bit         last_xfer = 1'b0;
  logic       obs_ready;

  bsg_link_credit_sender_if #(.width_p(9), .credit_max_p(16)) link_if ();

  bsg_link_credit_sender #(
    .width_p(9),
    .credit_max_p(16),
    .credit_decimation_p(4),
    .startup_cycles_p(8)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .link   (link_if)
  );

  always #5 clk = ~clk;

  // Global time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock cycle: sample ready mid-cycle, advance the model at the edge, settle
  task automatic tick();
    int  n;
    bit  te;
    @(negedge clk);
    exp_ready = (m_cyc >= 8) && (m_cred > 0);
    obs_ready = link_if.ready_o;
    @(posedge clk);
    if (reset) begin
      m_cyc      = 0;
      m_cred     = 16;
      m_err      = 1'b0;
      m_tkn_prev = link_if.link_tkn_i;
      exp_link_v = 1'b0;
      exp_data   = '0;
      last_xfer  = 1'b0;
    end else begin
      last_xfer  = link_if.v_i && exp_ready;
      te         = (link_if.link_tkn_i != m_tkn_prev);
      m_tkn_prev = link_if.link_tkn_i;
      n = m_cred - (last_xfer ? 1 : 0) + (te ? 4 : 0);
      if (n > 16) begin
        n     = 16;
        m_err = 1'b1;
      end
      m_cred     = n;
      m_cyc      = m_cyc + 1;
      exp_link_v = last_xfer;
      if (last_xfer) exp_data = link_if.data_i;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    link_if.v_i        = 1'b0;
    link_if.data_i     = '0;
    link_if.link_tkn_i = 1'b0;
    do_reset();
    checks++; if (link_if.link_v_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_link_v: got %0b expected 0", link_if.link_v_o); end
    checks++; if (link_if.link_data_o !== 9'd0) begin errors++; $display("[TB] FAIL reset_link_data: got %0h expected 0", link_if.link_data_o); end
    checks++; if (link_if.credits_o !== 5'd16) begin errors++; $display("[TB] FAIL reset_credits: got %0d expected 16", link_if.credits_o); end
    checks++; if (link_if.active_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %0b expected 0", link_if.active_o); end
    checks++; if (link_if.error_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %0b expected 0", link_if.error_o); end
    checks++; if (link_if.ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 0", link_if.ready_o); end
  endtask

  // Constant valid from reset: 8 idle cycles, 16 words back to back, then stall
  task automatic test_startup_drain();
    logic [8:0] drv [30];
    bit         want;
    link_if.v_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      drv[i] = 9'($urandom);
      link_if.data_i = drv[i];
      tick();
      want = (i >= 8) && (i < 24);
      checks++; if (obs_ready !== want) begin errors++; $display("[TB] FAIL drain_ready[%0d]: got %0b expected %0b", i, obs_ready, want); end
      checks++; if (link_if.link_v_o !== want) begin errors++; $display("[TB] FAIL drain_link_v[%0d]: got %0b expected %0b", i, link_if.link_v_o, want); end
      if (want) begin
        checks++; if (link_if.link_data_o !== drv[i]) begin errors++; $display("[TB] FAIL drain_data[%0d]: got %0h expected %0h", i, link_if.link_data_o, drv[i]); end
      end
      checks++; if (link_if.credits_o !== 5'(m_cred)) begin errors++; $display("[TB] FAIL drain_credits[%0d]: got %0d expected %0d", i, link_if.credits_o, m_cred); end
    end
    checks++; if (link_if.credits_o !== 5'd0) begin errors++; $display("[TB] FAIL drain_end_credits: got %0d expected 0", link_if.credits_o); end
    checks++; if (link_if.ready_o !== 1'b0) begin errors++; $display("[TB] FAIL drain_end_ready: got %0b expected 0", link_if.ready_o); end
    checks++; if (link_if.link_data_o !== drv[23]) begin errors++; $display("[TB] FAIL drain_data_hold: got %0h expected %0h", link_if.link_data_o, drv[23]); end
    link_if.v_i = 1'b0;
  endtask

  // One token toggle from empty refills exactly four words
  task automatic test_token_refill();
    logic [8:0] drv [7];
    link_if.v_i        = 1'b0;
    link_if.link_tkn_i = ~link_if.link_tkn_i;
    tick();
    checks++; if (link_if.credits_o !== 5'd4) begin errors++; $display("[TB] FAIL refill_credits: got %0d expected 4", link_if.credits_o); end
    link_if.v_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drv[i] = 9'($urandom);
      link_if.data_i = drv[i];
      tick();
      checks++; if (link_if.link_v_o !== (i < 4)) begin errors++; $display("[TB] FAIL refill_link_v[%0d]: got %0b expected %0b", i, link_if.link_v_o, (i < 4)); end
      if (i < 4) begin
        checks++; if (link_if.link_data_o !== drv[i]) begin errors++; $display("[TB] FAIL refill_data[%0d]: got %0h expected %0h", i, link_if.link_data_o, drv[i]); end
      end
    end
    link_if.v_i = 1'b0;
    checks++; if (link_if.credits_o !== 5'd0) begin errors++; $display("[TB] FAIL refill_end_credits: got %0d expected 0", link_if.credits_o); end
  endtask

  // Send and token edge in the same cycle apply together
  task automatic test_simultaneous();
    logic [8:0] d1;
    link_if.v_i        = 1'b0;
    link_if.link_tkn_i = ~link_if.link_tkn_i;
    tick();
    link_if.v_i    = 1'b1;
    link_if.data_i = 9'($urandom);
    tick();
    checks++; if (link_if.credits_o !== 5'd3) begin errors++; $display("[TB] FAIL simul_pre_credits: got %0d expected 3", link_if.credits_o); end
    d1 = 9'($urandom);
    link_if.data_i     = d1;
    link_if.link_tkn_i = ~link_if.link_tkn_i;
    tick();
    checks++; if (link_if.credits_o !== 5'd6) begin errors++; $display("[TB] FAIL simul_credits: got %0d expected 6", link_if.credits_o); end
    checks++; if (link_if.error_o !== 1'b0) begin errors++; $display("[TB] FAIL simul_error: got %0b expected 0", link_if.error_o); end
    checks++; if (link_if.link_v_o !== 1'b1) begin errors++; $display("[TB] FAIL simul_link_v: got %0b expected 1", link_if.link_v_o); end
    checks++; if (link_if.link_data_o !== d1) begin errors++; $display("[TB] FAIL simul_data: got %0h expected %0h", link_if.link_data_o, d1); end
    link_if.v_i = 1'b0;
  endtask

  // Token edge at full credit clamps and latches the sticky error until reset
  task automatic test_overflow();
    link_if.v_i = 1'b0;
    do_reset();
    link_if.link_tkn_i = ~link_if.link_tkn_i;
    tick();
    checks++; if (link_if.credits_o !== 5'd16) begin errors++; $display("[TB] FAIL ovf_credits: got %0d expected 16", link_if.credits_o); end
    checks++; if (link_if.error_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_error: got %0b expected 1", link_if.error_o); end
    for (int i = 0; i < 12; i++) begin
      link_if.v_i = (i >= 8);
      tick();
      checks++; if (link_if.error_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky[%0d]: got %0b expected 1", i, link_if.error_o); end
    end
    link_if.v_i = 1'b0;
    do_reset();
    checks++; if (link_if.error_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared: got %0b expected 0", link_if.error_o); end
  endtask

  // Random traffic with a receiver that returns one toggle per four words received
  task automatic test_random();
    logic [8:0] sent [$];
    logic [8:0] rcv [$];
    int         pend [$];
    int         rcv_cnt  = 0;
    int         returned = 0;
    int         last_due = 0;
    int         due;
    link_if.v_i = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 750; cyc++) begin
      if (pend.size() > 0 && pend[0] <= cyc) begin
        link_if.link_tkn_i = ~link_if.link_tkn_i;
        void'(pend.pop_front());
        returned++;
      end
      link_if.v_i    = (cyc < 600) ? ($urandom_range(0, 3) != 0) : 1'b0;
      link_if.data_i = 9'($urandom);
      tick();
      if (last_xfer) sent.push_back(link_if.data_i);
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL rand_ready[%0d]: got %0b expected %0b", cyc, obs_ready, exp_ready); end
      checks++; if (link_if.credits_o !== 5'(m_cred)) begin errors++; $display("[TB] FAIL rand_credits[%0d]: got %0d expected %0d", cyc, link_if.credits_o, m_cred); end
      checks++; if (link_if.link_v_o !== exp_link_v) begin errors++; $display("[TB] FAIL rand_link_v[%0d]: got %0b expected %0b", cyc, link_if.link_v_o, exp_link_v); end
      checks++; if (int'(link_if.credits_o) > 16) begin errors++; $display("[TB] FAIL rand_underflow[%0d]: got %0d expected <=16", cyc, link_if.credits_o); end
      if (link_if.link_v_o === 1'b1) begin
        rcv.push_back(link_if.link_data_o);
        rcv_cnt++;
        if (rcv_cnt % 4 == 0) begin
          due = cyc + $urandom_range(1, 6);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back(due);
        end
      end
      checks++; if (rcv_cnt - 4 * returned > 16) begin errors++; $display("[TB] FAIL rand_outstanding[%0d]: got %0d expected <=16", cyc, rcv_cnt - 4 * returned); end
    end
    checks++; if (pend.size() != 0) begin errors++; $display("[TB] FAIL rand_tokens_drained: got %0d pending expected 0", pend.size()); end
    checks++; if (rcv.size() != sent.size()) begin errors++; $display("[TB] FAIL rand_count: got %0d received expected %0d", rcv.size(), sent.size()); end
    for (int k = 0; k < sent.size() && k < rcv.size(); k++) begin
      checks++; if (rcv[k] !== sent[k]) begin errors++; $display("[TB] FAIL rand_order[%0d]: got %0h expected %0h", k, rcv[k], sent[k]); end
    end
    checks++; if (int'(link_if.credits_o) != 16 - sent.size() + 4 * returned) begin errors++; $display("[TB] FAIL rand_final_credits: got %0d expected %0d", link_if.credits_o, 16 - sent.size() + 4 * returned); end
    checks++; if (link_if.error_o !== 1'b0) begin errors++; $display("[TB] FAIL rand_error: got %0b expected 0", link_if.error_o); end
  endtask

  // Reset with traffic in flight drops the word and restarts the startup wait
  task automatic test_reset_midstream();
    link_if.v_i = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    link_if.v_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      link_if.data_i = 9'($urandom);
      tick();
    end
    checks++; if (link_if.credits_o !== 5'd5) begin errors++; $display("[TB] FAIL mid_pre_credits: got %0d expected 5", link_if.credits_o); end
    link_if.data_i = 9'($urandom);
    do_reset();
    checks++; if (link_if.link_v_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_link_v: got %0b expected 0", link_if.link_v_o); end
    checks++; if (link_if.credits_o !== 5'd16) begin errors++; $display("[TB] FAIL mid_credits: got %0d expected 16", link_if.credits_o); end
    checks++; if (link_if.active_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_active: got %0b expected 0", link_if.active_o); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (obs_ready !== (i >= 8)) begin errors++; $display("[TB] FAIL mid_restart_ready[%0d]: got %0b expected %0b", i, obs_ready, (i >= 8)); end
    end
    link_if.v_i = 1'b0;
  endtask

  initial begin
    $display("[TB] starting bsg_link_credit_sender bench");
    test_reset();
    test_startup_drain();
    test_token_refill();
    test_simultaneous();
    test_overflow();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
